pci_target_seq: RTL and testbench
=================================

PCI_TARGET_SEQ -- requirements
Module: pci_target_seq

Interface
REQ-001 Parameter MAX_BURST, default 16: maximum data phases per access before a target disconnect.
REQ-002 Parameter FIRST_TMO, default 12: clocks allowed for first read data before a target retry (must be < 16).
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 acc_start  in  1  one-cycle pulse: address phase decoded with card hit.
REQ-006 start_adr  in  30  dword address captured on acc_start.
REQ-007 acc_rd / acc_wr  in  1 each  access direction, stable from acc_start to acc_end.
REQ-008 t_nextd  in  1  PCI side consumed one data phase (read: data taken; write: data latched).
REQ-009 t_we / t_wdata  in  1 / 32  write strobe and write data from the PCI side.
REQ-010 acc_end  in  1  PCI access finished (turnaround).
REQ-011 t_drdy, t_term, t_abort  out  1 each  to the target FSM: data ready, disconnect/retry, target abort.
REQ-012 t_rdata  out  32  read data to the AD output registers.
REQ-013 lb_req, lb_we  out  1 each  local-bus request and direction; lb_adr  out  30; lb_wdata  out  32.
REQ-014 lb_ack, lb_err  in  1 each  local-bus completion and error (sampled only with lb_ack); lb_rdata  in  32.

Function
REQ-015 State machine SHALL have states IDLE, RD_FETCH, RD_HOLD, WR_EMPTY, WR_BUSY, FLUSH.
REQ-016 IDLE: on acc_start, load adr<=start_adr and clear counters; go to RD_FETCH if acc_rd, else WR_EMPTY.
REQ-017 RD_FETCH: lb_req=1, lb_we=0, lb_adr=adr; on lb_ack, register lb_rdata into t_rdata and go to RD_HOLD, so t_drdy=1 one clock after lb_ack.
REQ-018 RD_HOLD: t_drdy=1; on t_nextd, adr<=adr+1, burst count +1, t_drdy=0 next clock; go to RD_FETCH.
REQ-019 WR_EMPTY: t_drdy=1; on t_we, latch t_wdata into lb_wdata and go to WR_BUSY; t_drdy=0 next clock.
REQ-020 WR_BUSY: lb_req=1, lb_we=1; on lb_ack, adr<=adr+1, burst count +1, go to WR_EMPTY.
REQ-021 lb_req SHALL stay asserted with lb_adr/lb_wdata stable until lb_ack; one transfer is outstanding at most.
REQ-022 Address SHALL wrap modulo 2^30 without error.
REQ-023 First-data timer runs only in RD_FETCH before the first read ack; at FIRST_TMO clocks without ack, t_term=1 (retry).
REQ-024 When burst count reaches MAX_BURST, t_term=1 and no further fetch/issue starts.
REQ-025 lb_ack with lb_err=1 SHALL set t_abort=1 and t_drdy=0; the data is discarded.
REQ-026 t_term and t_abort SHALL be sticky until acc_end.
REQ-027 acc_end from any state: if lb_req is outstanding, go to FLUSH; otherwise go to IDLE. All sticky flags and t_drdy clear the next clock.
REQ-028 FLUSH: keep lb_req held until lb_ack, discard the result, then go to IDLE; acc_start received during FLUSH is held pending and serviced on exit.
REQ-029 If t_nextd and acc_end occur in the same clock, the address increment SHALL still occur, and acc_end priority then applies.
REQ-030 acc_start while not IDLE and not FLUSH is a protocol error and SHALL be ignored.

Reset
REQ-031 rst SHALL force state to IDLE and clear adr, both counters, and the pending flag.
REQ-032 rst SHALL drive t_drdy, t_term, t_abort, lb_req and lb_we to 0, and t_rdata and lb_wdata to 0.
REQ-033 Reset asserted mid-transfer SHALL abandon lb_req immediately, with no flush.

Structure
REQ-034 State encodings, MAX_BURST and FIRST_TMO defaults SHALL live in shared package pci_pkg.
REQ-035 The burst and first-data counters MAY form one sub-module, pci_seq_cnt, with load/increment/terminal-count outputs; everything else stays flat.

Verification
REQ-036 Read, start_adr=0x100, lb_ack after 2 clocks, four t_nextd -> lb_adr sequence 0x100..0x103; t_drdy 1 clock after each lb_ack.
REQ-037 Write burst of 3 with t_wdata A,B,C and lb_ack delayed by 3 clocks -> t_drdy low during each WR_BUSY; lb_wdata order A,B,C at 0x200..0x202.
REQ-038 Read with no lb_ack for 12 clocks -> t_term=1 on clock 12; after acc_end, state=FLUSH until the late lb_ack, then IDLE.
REQ-039 Read with 16 data phases (MAX_BURST=16) -> t_term=1 after the 16th t_nextd; no 17th lb_req.
REQ-040 lb_ack with lb_err on the 2nd write -> t_abort=1 until acc_end; adr is not incremented.
REQ-041 rst pulse while in WR_BUSY -> all outputs return to their reset values asynchronously; a following acc_start operates normally.

Source files
------------

// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI target local-bus sequencer.
//   seq_state_t       - sequencer state encoding
//   MAX_BURST_DEF     - default data phases per access before disconnect
//   FIRST_TMO_DEF     - default clocks allowed for first read data (< 16)
//   ADR_W / DATA_W    - dword address and data widths
package pci_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_HOLD  = 3'd2,
        WR_EMPTY = 3'd3,
        WR_BUSY  = 3'd4,
        FLUSH    = 3'd5
    } seq_state_t;

    localparam int MAX_BURST_DEF = 16;
    localparam int FIRST_TMO_DEF = 12;
    localparam int ADR_W         = 30;
    localparam int DATA_W        = 32;

endpackage

// File: rtl/pci_seq_cnt.sv
// pci_seq_cnt: burst counter and first-data timer for pci_target_seq.
//   clk, rst      - clock, asynchronous active-high reset
//   i_clr         - clear both counters (start of a new access)
//   i_burst_inc   - one data phase completed
//   i_tmr_run     - count one clock of waiting for the first read data
//   o_burst_last  - next i_burst_inc reaches MAX_BURST
//   o_tmr_last    - next i_tmr_run reaches FIRST_TMO
module pci_seq_cnt
    import pci_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int FIRST_TMO = FIRST_TMO_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_burst_inc,
    input  logic i_tmr_run,
    output logic o_burst_last,
    output logic o_tmr_last
);

    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] r_burst;
    logic [3:0]    r_tmr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst <= '0;
            r_tmr   <= '0;
        end else if (i_clr) begin
            r_burst <= '0;
            r_tmr   <= '0;
        end else begin
            if (i_burst_inc) r_burst <= r_burst + 1'b1;
            if (i_tmr_run)   r_tmr   <= r_tmr + 1'b1;
        end
    end

    assign o_burst_last = (r_burst == BW'(MAX_BURST - 1));
    assign o_tmr_last   = (r_tmr == 4'(FIRST_TMO - 1));

endmodule

// File: rtl/pci_target_seq.sv
// pci_target_seq: bridges PCI target data phases to a single-outstanding
// local-bus transfer. Reads fetch one dword ahead of each data phase;
// writes post one dword at a time.
//   clk, rst                 - clock, asynchronous active-high reset
//   acc_start/start_adr      - decoded address phase and dword address
//   acc_rd/acc_wr            - access direction, held for the access
//   t_nextd, t_we/t_wdata    - PCI data phase consumed / write data
//   acc_end                  - PCI access finished
//   t_drdy/t_term/t_abort    - data ready, disconnect-retry, target abort
//   t_rdata                  - read data to the AD registers
//   lb_req/lb_we/lb_adr/lb_wdata - local-bus request side
//   lb_ack/lb_err/lb_rdata   - local-bus completion side
module pci_target_seq
    import pci_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int FIRST_TMO = FIRST_TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_start,
    input  logic [ADR_W-1:0]  start_adr,
    input  logic              acc_rd,
    input  logic              acc_wr,
    input  logic              t_nextd,
    input  logic              t_we,
    input  logic [DATA_W-1:0] t_wdata,
    input  logic              acc_end,
    output logic              t_drdy,
    output logic              t_term,
    output logic              t_abort,
    output logic [DATA_W-1:0] t_rdata,
    output logic              lb_req,
    output logic              lb_we,
    output logic [ADR_W-1:0]  lb_adr,
    output logic [DATA_W-1:0] lb_wdata,
    input  logic              lb_ack,
    input  logic              lb_err,
    input  logic [DATA_W-1:0] lb_rdata
);

    seq_state_t        r_state, w_next;
    logic [ADR_W-1:0]  r_adr, r_pend_adr, w_load_adr;
    logic [DATA_W-1:0] r_rdata, r_wdata;
    logic r_pend, r_pend_rd, r_wr, r_first, r_term, r_abort;
    logic w_new, w_in_acc, w_drdy, w_rd_take, w_wr_take, w_rd_ack, w_wr_ack;
    logic w_flush_done, w_load, w_load_rd, w_burst_inc, w_tmr_run;
    logic w_burst_last, w_tmr_last;

    // An address phase with neither direction set is not started.
    assign w_new        = acc_start & (acc_rd | acc_wr);
    assign w_in_acc     = (r_state != IDLE) && (r_state != FLUSH);
    assign w_rd_take    = (r_state == RD_HOLD) & w_drdy & t_nextd;
    assign w_wr_take    = (r_state == WR_EMPTY) & w_drdy & t_we;
    assign w_rd_ack     = (r_state == RD_FETCH) & lb_ack;
    assign w_wr_ack     = (r_state == WR_BUSY) & lb_ack;
    assign w_flush_done = (r_state == FLUSH) & lb_ack;
    // A start held during FLUSH wins over one arriving on the exit clock.
    assign w_load       = ((r_state == IDLE) & w_new) | (w_flush_done & (r_pend | w_new));
    assign w_load_adr   = r_pend ? r_pend_adr : start_adr;
    assign w_load_rd    = r_pend ? r_pend_rd : acc_rd;
    // Errored write completions do not advance the address or burst.
    assign w_burst_inc  = w_rd_take | (w_wr_ack & ~lb_err);
    assign w_tmr_run    = (r_state == RD_FETCH) & ~lb_ack & ~r_first & ~r_term;

    pci_seq_cnt #(
        .MAX_BURST (MAX_BURST),
        .FIRST_TMO (FIRST_TMO)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_load),
        .i_burst_inc  (w_burst_inc),
        .i_tmr_run    (w_tmr_run),
        .o_burst_last (w_burst_last),
        .o_tmr_last   (w_tmr_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_new) w_next = acc_rd ? RD_FETCH : WR_EMPTY;
            RD_FETCH: if (lb_ack) w_next = RD_HOLD;
            // The last phase of a burst parks in RD_HOLD so nothing is prefetched.
            RD_HOLD:  if (w_rd_take && !w_burst_last) w_next = RD_FETCH;
            WR_EMPTY: if (w_wr_take) w_next = WR_BUSY;
            WR_BUSY:  if (lb_ack) w_next = WR_EMPTY;
            FLUSH:    if (lb_ack) w_next = w_load ? (w_load_rd ? RD_FETCH : WR_EMPTY) : IDLE;
            default:  w_next = IDLE;
        endcase
        if (acc_end && w_in_acc)
            w_next = (lb_req && !lb_ack) ? FLUSH : IDLE;
    end

    // Outputs decoded from state; term/abort suppress data-ready.
    always_comb begin
        lb_req = (r_state == RD_FETCH) || (r_state == WR_BUSY) || (r_state == FLUSH);
        lb_we  = (r_state == WR_BUSY) || ((r_state == FLUSH) && r_wr);
        w_drdy = ((r_state == RD_HOLD) || (r_state == WR_EMPTY)) && !r_term && !r_abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr      <= '0;
            r_pend_adr <= '0;
            r_pend     <= 1'b0;
            r_pend_rd  <= 1'b0;
            r_wr       <= 1'b0;
            r_first    <= 1'b0;
            r_term     <= 1'b0;
            r_abort    <= 1'b0;
            r_rdata    <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_load)           r_adr <= w_load_adr;
            else if (w_burst_inc) r_adr <= r_adr + 1'b1;

            if (w_load) r_wr <= ~w_load_rd;

            if (w_load)        r_first <= 1'b0;
            else if (w_rd_ack) r_first <= 1'b1;

            if (w_load || acc_end)
                r_term <= 1'b0;
            else if ((w_tmr_run && w_tmr_last) || (w_burst_inc && w_burst_last))
                r_term <= 1'b1;

            if (w_load || acc_end)
                r_abort <= 1'b0;
            else if ((w_rd_ack || w_wr_ack) && lb_err)
                r_abort <= 1'b1;

            if (w_rd_ack && !lb_err) r_rdata <= lb_rdata;
            if (w_wr_take)           r_wdata <= t_wdata;

            if (w_flush_done) begin
                r_pend <= 1'b0;
            end else if ((r_state == FLUSH) && w_new && !r_pend) begin
                r_pend     <= 1'b1;
                r_pend_adr <= start_adr;
                r_pend_rd  <= acc_rd;
            end
        end
    end

    assign t_drdy   = w_drdy;
    assign t_term   = r_term;
    assign t_abort  = r_abort;
    assign t_rdata  = r_rdata;
    assign lb_adr   = r_adr;
    assign lb_wdata = r_wdata;

endmodule

// File: tb/tb_pci_target_seq.sv
module tb_pci_target_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_start, acc_rd, acc_wr, t_nextd, t_we, acc_end;
    logic [29:0] start_adr;
    logic [31:0] t_wdata;
    logic        t_drdy, t_term, t_abort, lb_req, lb_we;
    logic [31:0] t_rdata, lb_wdata, lb_rdata;
    logic [29:0] lb_adr;
    logic        lb_ack, lb_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [29:0] adr; logic we; logic [31:0] data; } lb_exp_t;
    typedef struct { int lat; logic [31:0] data; logic err; } resp_t;

    lb_exp_t     lbq[$];
    logic [31:0] rdq[$];
    resp_t       respq[$];

    always #5 clk = ~clk;

    pci_target_seq dut (
        .clk(clk), .rst(rst), .acc_start(acc_start), .start_adr(start_adr),
        .acc_rd(acc_rd), .acc_wr(acc_wr), .t_nextd(t_nextd), .t_we(t_we),
        .t_wdata(t_wdata), .acc_end(acc_end), .t_drdy(t_drdy), .t_term(t_term),
        .t_abort(t_abort), .t_rdata(t_rdata), .lb_req(lb_req), .lb_we(lb_we),
        .lb_adr(lb_adr), .lb_wdata(lb_wdata), .lb_ack(lb_ack), .lb_err(lb_err),
        .lb_rdata(lb_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [29:0] adr, input logic [31:0] data, input int lat);
        lb_exp_t e;
        resp_t   r;
        e.adr = adr; e.we = 1'b0; e.data = 32'h0;
        r.lat = lat; r.data = data; r.err = 1'b0;
        lbq.push_back(e);
        respq.push_back(r);
        rdq.push_back(data);
    endtask

    task automatic push_wr(input logic [29:0] adr, input logic [31:0] data, input int lat, input logic err);
        lb_exp_t e;
        resp_t   r;
        e.adr = adr; e.we = 1'b1; e.data = data;
        r.lat = lat; r.data = 32'h0; r.err = err;
        lbq.push_back(e);
        respq.push_back(r);
    endtask

    task automatic start(input logic [29:0] adr, input logic rd);
        acc_start = 1'b1; start_adr = adr; acc_rd = rd; acc_wr = ~rd;
        tick();
        acc_start = 1'b0;
    endtask

    task automatic end_acc();
        acc_end = 1'b1;
        tick();
        acc_end = 1'b0;
    endtask

    task automatic wait_drdy(input string nm, output int k);
        k = 0;
        while (!t_drdy && k < 60) begin
            tick();
            k++;
        end
        chk(nm, 32'(t_drdy), 32'h1);
    endtask

    task automatic write_beat(input logic [31:0] data, input int lat);
        int k;
        chk("wr_empty_drdy", 32'(t_drdy), 32'h1);
        t_we = 1'b1; t_wdata = data;
        tick();
        t_we = 1'b0;
        k = 0;
        while (lb_req && k < 40) begin
            chk("wr_busy_drdy", 32'(t_drdy), 32'h0);
            tick();
            k++;
        end
        chk("wr_ack_lat", 32'(k), 32'(lat));
    endtask

    // Local-bus responder: per request, ack after the scripted latency.
    initial begin
        resp_t r;
        lb_ack = 1'b0; lb_err = 1'b0; lb_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (lb_req) begin
                if (respq.size() > 0) r = respq.pop_front();
                else begin r.lat = 1; r.data = 32'h0; r.err = 1'b0; end
                repeat (r.lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                lb_ack = 1'b1; lb_rdata = r.data; lb_err = r.err;
                @(posedge clk);
                #1;
                lb_ack = 1'b0; lb_err = 1'b0;
            end
        end
    end

    // Scoreboard monitor: local-bus handshakes and read data phases.
    always @(negedge clk) begin
        lb_exp_t     e;
        logic [31:0] d;
        if (!rst && lb_req && lb_ack) begin
            if (lbq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL lb_xfer: unexpected transfer adr 0x%0h, none expected", lb_adr);
            end else begin
                e = lbq.pop_front();
                chk("lb_adr", 32'(lb_adr), 32'(e.adr));
                chk("lb_we", 32'(lb_we), 32'(e.we));
                if (e.we) chk("lb_wdata", lb_wdata, e.data);
            end
        end
        if (!rst && t_drdy && t_nextd) begin
            if (rdq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_phase: unexpected data 0x%0h, none expected", t_rdata);
            end else begin
                d = rdq.pop_front();
                chk("t_rdata", t_rdata, d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] wd [3];
        acc_start = 0; acc_rd = 0; acc_wr = 0; t_nextd = 0; t_we = 0; acc_end = 0;
        start_adr = '0; t_wdata = '0;
        wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003;

        // Reset state
        #2;
        chk("rst_drdy", 32'(t_drdy), 32'h0);
        chk("rst_term", 32'(t_term), 32'h0);
        chk("rst_abort", 32'(t_abort), 32'h0);
        chk("rst_lb_req", 32'(lb_req), 32'h0);
        chk("rst_lb_we", 32'(lb_we), 32'h0);
        chk("rst_rdata", t_rdata, 32'h0);
        chk("rst_wdata", lb_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Read burst of four, ack latency 2; last phase ends the access
        for (int i = 0; i < 4; i++) push_rd(30'h100 + 30'(i), 32'hD100_0000 + 32'(i), 2);
        start(30'h100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_drdy("t1_drdy", k);
            chk("t1_drdy_lat", 32'(k), 32'd2);
            t_nextd = 1'b1;
            if (i == 3) acc_end = 1'b1;
            tick();
            t_nextd = 1'b0; acc_end = 1'b0;
        end
        chk("t1_adr_inc_on_end", 32'(lb_adr), 32'h104);
        chk("t1_idle_req", 32'(lb_req), 32'h0);
        chk("t1_idle_drdy", 32'(t_drdy), 32'h0);

        // Write burst of three, ack latency 3
        for (int i = 0; i < 3; i++) push_wr(30'h200 + 30'(i), wd[i], 3, 1'b0);
        start(30'h200, 1'b0);
        for (int i = 0; i < 3; i++) write_beat(wd[i], 3);
        end_acc();
        chk("t2_adr", 32'(lb_adr), 32'h203);
        chk("t2_idle_drdy", 32'(t_drdy), 32'h0);

        // First-data timeout, flush, pending start, address wrap
        begin
            lb_exp_t e;
            resp_t   r;
            e.adr = 30'h300; e.we = 1'b0; e.data = 32'h0;
            r.lat = 20; r.data = 32'hBAD0_0300; r.err = 1'b0;
            lbq.push_back(e);
            respq.push_back(r);
        end
        start(30'h300, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("t3_term_clk%0d", c), 32'(t_term), 32'(c == 12));
        end
        end_acc();
        chk("t3_flush_req", 32'(lb_req), 32'h1);
        chk("t3_flush_term_clr", 32'(t_term), 32'h0);
        chk("t3_flush_drdy", 32'(t_drdy), 32'h0);
        chk("t3_flush_adr", 32'(lb_adr), 32'h300);
        push_rd(30'h3FFF_FFFF, 32'h5555_0001, 1);
        push_rd(30'h0, 32'h5555_0002, 1);
        acc_start = 1'b1; start_adr = 30'h3FFF_FFFF; acc_rd = 1'b1; acc_wr = 1'b0;
        tick();
        acc_start = 1'b0;
        k = 0;
        while (lb_adr == 30'h300 && k < 40) begin
            chk("t3_flush_hold", 32'(lb_req), 32'h1);
            tick();
            k++;
        end
        chk("t3_flush_len", 32'(k), 32'd6);
        chk("t3_pend_term", 32'(t_term), 32'h0);
        wait_drdy("t3_drdy_a", k);
        t_nextd = 1'b1; tick(); t_nextd = 1'b0;
        wait_drdy("t3_drdy_b", k);
        t_nextd = 1'b1; acc_end = 1'b1; tick(); t_nextd = 1'b0; acc_end = 1'b0;
        chk("t3_wrap_adr", 32'(lb_adr), 32'h1);

        // Sixteen-phase read hits the burst limit; stray start ignored
        for (int i = 0; i < 16; i++) push_rd(30'h10 + 30'(i), 32'hC000_0000 + 32'(i), 1);
        start(30'h10, 1'b1);
        for (int i = 0; i < 16; i++) begin
            wait_drdy("t4_drdy", k);
            if (i == 5) begin
                acc_start = 1'b1; start_adr = 30'h123;
                tick();
                acc_start = 1'b0;
            end
            t_nextd = 1'b1; tick(); t_nextd = 1'b0;
        end
        chk("t4_term", 32'(t_term), 32'h1);
        for (int j = 0; j < 4; j++) begin
            chk("t4_no_fetch", 32'(lb_req), 32'h0);
            chk("t4_no_drdy", 32'(t_drdy), 32'h0);
            tick();
        end
        end_acc();
        chk("t4_term_clr", 32'(t_term), 32'h0);
        chk("t4_adr", 32'(lb_adr), 32'h20);

        // Error on the second write
        push_wr(30'h050, 32'h1111_AAAA, 1, 1'b0);
        push_wr(30'h051, 32'h2222_BBBB, 1, 1'b1);
        start(30'h050, 1'b0);
        write_beat(32'h1111_AAAA, 1);
        write_beat(32'h2222_BBBB, 1);
        chk("t5_abort", 32'(t_abort), 32'h1);
        chk("t5_drdy", 32'(t_drdy), 32'h0);
        chk("t5_adr_hold", 32'(lb_adr), 32'h051);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t5_abort_sticky", 32'(t_abort), 32'h1);
            chk("t5_no_req", 32'(lb_req), 32'h0);
        end
        end_acc();
        chk("t5_abort_clr", 32'(t_abort), 32'h0);

        // Asynchronous reset while WR_BUSY
        begin
            resp_t r;
            r.lat = 10; r.data = 32'h0; r.err = 1'b0;
            respq.push_back(r);
        end
        start(30'h400, 1'b0);
        t_we = 1'b1; t_wdata = 32'hDEAD_BEEF;
        tick();
        t_we = 1'b0;
        chk("t6_busy_req", 32'(lb_req), 32'h1);
        chk("t6_busy_we", 32'(lb_we), 32'h1);
        chk("t6_busy_wdata", lb_wdata, 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(lb_req), 32'h0);
        chk("t6_rst_we", 32'(lb_we), 32'h0);
        chk("t6_rst_drdy", 32'(t_drdy), 32'h0);
        chk("t6_rst_term", 32'(t_term), 32'h0);
        chk("t6_rst_abort", 32'(t_abort), 32'h0);
        chk("t6_rst_wdata", lb_wdata, 32'h0);
        chk("t6_rst_rdata", t_rdata, 32'h0);
        chk("t6_rst_adr", 32'(lb_adr), 32'h0);
        #2 rst = 1'b0;
        repeat (15) tick();
        push_rd(30'h7, 32'h7777_0007, 1);
        start(30'h7, 1'b1);
        wait_drdy("t6_post_drdy", k);
        t_nextd = 1'b1; acc_end = 1'b1; tick(); t_nextd = 1'b0; acc_end = 1'b0;
        chk("t6_post_adr", 32'(lb_adr), 32'h8);

        tick();
        chk("lb_queue_drained", 32'(lbq.size()), 32'h0);
        chk("rd_queue_drained", 32'(rdq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
